// File: rtl/mux_scanner_pkg.sv
// mux_scanner_pkg: state encoding and limits shared by 151/152 scan controllers.
package mux_scanner_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;
    localparam int SETTLE_MAX = 15;
    localparam logic STR_INHIBIT = 1'b1;
endpackage

// File: rtl/scan_timer.sv
// scan_timer: settle counter; tick marks the cycle a channel is sampled.
module scan_timer
    import mux_scanner_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);
    localparam logic [3:0] LIM = 4'(SETTLE > SETTLE_MAX ? SETTLE_MAX : SETTLE);
    logic [3:0] wcnt;
    assign tick = wcnt == LIM;
    // Held at zero outside a scan so every scan entry starts a fresh bit period.
    always_ff @(posedge clk or posedge rst)
        if (rst) wcnt <= 4'd0;
        else wcnt <= (en && !tick) ? wcnt + 4'd1 : 4'd0;
endmodule

// File: rtl/mux_scanner.sv
// mux_scanner: walks an SN74XX151 through all eight channels and hands off the sampled byte.
module mux_scanner
    import mux_scanner_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cont,
    output logic [2:0] sel,
    output logic       str,
    input  logic       mux_out,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       busy
);
    state_t state, state_d;
    logic tick;
    scan_timer #(.SETTLE(SETTLE)) u_timer (
        .clk (clk),
        .rst (rst),
        .en  (state == SCAN),
        .tick(tick)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_d;
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = start ? SCAN : IDLE;
            SCAN:    state_d = (tick && sel == 3'd7) ? DONE : SCAN;
            DONE:    state_d = ready ? (cont ? SCAN : IDLE) : DONE;
            default: state_d = IDLE;
        endcase
    end
    // sel wraps 7->0 on the final sample, which is exactly the exit from SCAN.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            sel  <= 3'd0;
            data <= 8'h00;
        end else if (state == SCAN && tick) begin
            data[sel] <= mux_out;
            sel       <= sel + 3'd1;
        end
    assign str   = (state == SCAN) ? ~STR_INHIBIT : STR_INHIBIT;
    assign valid = state == DONE;
    assign busy  = state == SCAN || state == DONE;
endmodule

// File: tb/tb_mux_scanner.sv
// tb_mux_scanner: checks mux_scanner (SETTLE=1 and SETTLE=0) against a behavioural 151 and scan model.
module tb_mux_scanner;
    localparam int S1 = 1;
    logic clk = 1'b0, rst = 1'b1;
    logic start1 = 0, cont1 = 0, ready1 = 0, str1, valid1, busy1, mux1;
    logic [2:0] sel1;
    logic [7:0] data1, a1 = 8'h00;
    logic start0 = 0, cont0 = 0, ready0 = 0, str0, valid0, busy0, mux0;
    logic [2:0] sel0;
    logic [7:0] data0, a0 = 8'h00;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;
    // Behavioural 151: strobe high forces the true output low.
    assign mux1 = str1 ? 1'b0 : a1[sel1];
    assign mux0 = str0 ? 1'b0 : a0[sel0];

    mux_scanner #(.SETTLE(S1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .cont(cont1), .sel(sel1), .str(str1),
        .mux_out(mux1), .data(data1), .valid(valid1), .ready(ready1), .busy(busy1)
    );
    mux_scanner #(.SETTLE(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .cont(cont0), .sel(sel0), .str(str0),
        .mux_out(mux0), .data(data0), .valid(valid0), .ready(ready0), .busy(busy0)
    );

    typedef struct {
        logic [7:0] a;
        int         delay;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs[10];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One scan on the SETTLE=1 instance; the byte must equal the channel levels held during the scan.
    task automatic run_scan(input logic [7:0] a, input int delay, input logic [7:0] exp);
        a1 = a;
        ready1 = (delay == 0);
        start1 = 1;
        cyc();
        start1 = 0;
        for (int j = 0; j < 8 * (S1 + 1); j++) begin
            chk("scan_sel", 32'(sel1), 32'(j / (S1 + 1)));
            chk("scan_str", 32'(str1), 0);
            chk("scan_valid", 32'(valid1), 0);
            if (j != 8 * (S1 + 1) - 1) cyc();
        end
        cyc();
        chk("done_valid", 32'(valid1), 1);
        chk("done_data", 32'(data1), 32'(exp));
        chk("done_str", 32'(str1), 1);
        chk("done_sel", 32'(sel1), 0);
        for (int d = 0; d < delay; d++) begin
            a1 = 8'($urandom);
            cyc();
            chk("hold_valid", 32'(valid1), 1);
            chk("hold_data", 32'(data1), 32'(exp));
        end
        ready1 = 1;
        cyc();
        chk("ack_valid", 32'(valid1), 0);
        chk("ack_busy", 32'(busy1), 0);
        chk("ack_data", 32'(data1), 32'(exp));
    endtask

    initial begin
        vecs[0] = '{8'hA5, 0, 8'hA5};
        vecs[1] = '{8'h3C, 5, 8'h3C};
        vecs[2] = '{8'h00, 0, 8'h00};
        vecs[3] = '{8'hFF, 2, 8'hFF};
        for (int i = 4; i < 10; i++) begin
            logic [7:0] r;
            r = 8'($urandom);
            vecs[i] = '{r, int'($urandom_range(0, 4)), r};
        end
        cyc();
        cyc();
        rst = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("idle_str", 32'(str1), 1);
            chk("idle_sel", 32'(sel1), 0);
            chk("idle_valid", 32'(valid1), 0);
            chk("idle_data", 32'(data1), 0);
            chk("idle_busy", 32'(busy1), 0);
        end

        for (int i = 0; i < 10; i++) run_scan(vecs[i].a, vecs[i].delay, vecs[i].exp);

        // Continuous mode: two bytes back to back, mid-scan start ignored.
        a1 = 8'h01;
        cont1 = 1;
        ready1 = 1;
        start1 = 1;
        cyc();
        start1 = 0;
        for (int j = 1; j < 16; j++) begin
            start1 = (j == 8);
            cyc();
            chk("cont1_valid", 32'(valid1), 0);
            chk("cont1_busy", 32'(busy1), 1);
        end
        start1 = 0;
        cyc();
        chk("cont1_valid_hi", 32'(valid1), 1);
        chk("cont1_data", 32'(data1), 32'h01);
        a1 = 8'h80;
        cyc();
        cont1 = 0;
        chk("cont2_entry_valid", 32'(valid1), 0);
        chk("cont2_entry_str", 32'(str1), 0);
        chk("cont2_entry_sel", 32'(sel1), 0);
        chk("cont2_entry_busy", 32'(busy1), 1);
        for (int j = 1; j < 16; j++) begin
            cyc();
            chk("cont2_valid", 32'(valid1), 0);
        end
        cyc();
        chk("cont2_valid_hi", 32'(valid1), 1);
        chk("cont2_data", 32'(data1), 32'h80);
        cyc();
        chk("cont2_idle", 32'(busy1), 0);

        // Asynchronous reset at channel 4 discards the partial byte.
        a1 = 8'h5A;
        start1 = 1;
        cyc();
        start1 = 0;
        for (int j = 0; j < 8; j++) cyc();
        chk("pre_rst_sel", 32'(sel1), 4);
        rst = 1;
        #2;
        chk("arst_sel", 32'(sel1), 0);
        chk("arst_str", 32'(str1), 1);
        chk("arst_data", 32'(data1), 0);
        chk("arst_busy", 32'(busy1), 0);
        cyc();
        rst = 0;
        run_scan(8'h5A, 1, 8'h5A);

        // SETTLE=0 instance: one edge per channel.
        a0 = 8'hFF;
        ready0 = 1;
        start0 = 1;
        cyc();
        start0 = 0;
        for (int j = 0; j < 8; j++) begin
            chk("s0_sel", 32'(sel0), 32'(j));
            chk("s0_valid", 32'(valid0), 0);
            if (j != 7) cyc();
        end
        cyc();
        chk("s0_valid_hi", 32'(valid0), 1);
        chk("s0_data", 32'(data0), 32'hFF);
        cyc();
        chk("s0_ack", 32'(valid0), 0);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] r;
            r = 8'($urandom);
            a0 = r;
            start0 = 1;
            cyc();
            start0 = 0;
            for (int j = 0; j < 8; j++) cyc();
            chk("s0_rand_valid", 32'(valid0), 1);
            chk("s0_rand_data", 32'(data0), 32'(r));
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
